// File: rtl/metro_turnstile_pkg.sv
// ---------------------------------------------------------------------------
// metro_turnstile_pkg
// Shared definitions for the metro turnstile access controller: the 2-bit
// state encoding (also exported on state_out for station status logic), the
// default access code, and counter widths.
// ---------------------------------------------------------------------------
package metro_turnstile_pkg;

  // Encoding is visible outside the block through state_out; keep it stable.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CHECK  = 2'b01,
    OPEN   = 2'b10,
    LOCKED = 2'b11
  } state_e;

  // Code that grants access unless the top is parameterised otherwise.
  localparam logic [3:0] DEFAULT_VALID_CODE = 4'd9;

  localparam int unsigned TIMER_W = 4;  // holds up to 15 cycles
  localparam int unsigned FAIL_W  = 3;  // holds up to 7 consecutive fails

endpackage : metro_turnstile_pkg

// File: rtl/turnstile_timer.sv
// ---------------------------------------------------------------------------
// turnstile_timer
// Small up-counter shared by the OPEN and LOCKED dwell periods. Cleared by
// load_i, advanced by inc_i, and flags when the count equals limit_i.
//
// Ports:
//   clk      system clock, rising edge
//   rset     synchronous active-low reset
//   load_i   restart the count at zero (wins over inc_i)
//   inc_i    advance the count by one
//   limit_i  terminal value to compare against
//   done_o   count currently equals limit_i
// ---------------------------------------------------------------------------
module turnstile_timer
  import metro_turnstile_pkg::*;
#(
  parameter int unsigned W = TIMER_W
) (
  input  logic         clk,
  input  logic         rset,
  input  logic         load_i,
  input  logic         inc_i,
  input  logic [W-1:0] limit_i,
  output logic         done_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + W'(1);
    end
  end

  assign done_o = (count_q == limit_i);

endmodule : turnstile_timer

// File: rtl/metro_turnstile.sv
// ---------------------------------------------------------------------------
// metro_turnstile
// Access-control FSM for a metro turnstile gate. A 4-bit code is captured
// when validate_code is seen in IDLE, checked for one cycle, and either opens
// the door for OPEN_CYCLES cycles or counts a failure. MAX_FAILS consecutive
// failures lock the gate for LOCK_CYCLES cycles.
//
// Ports:
//   clk               system clock, rising edge
//   rset              synchronous active-low reset, priority over everything
//   validate_code     level request to check access_code (IDLE only)
//   access_code       code presented by the reader
//   open_access_door  door open command, high only in OPEN (registered)
//   state_out         current state register (IDLE/CHECK/OPEN/LOCKED)
// ---------------------------------------------------------------------------
module metro_turnstile
  import metro_turnstile_pkg::*;
#(
  parameter logic [3:0]  VALID_CODE  = DEFAULT_VALID_CODE,
  parameter int unsigned OPEN_CYCLES = 4,   // 1..15
  parameter int unsigned MAX_FAILS   = 3,   // 1..7
  parameter int unsigned LOCK_CYCLES = 8    // 1..15
) (
  input  logic       clk,
  input  logic       rset,
  input  logic       validate_code,
  input  logic [3:0] access_code,
  output logic       open_access_door,
  output logic [1:0] state_out
);

  // Timer terminal values: the timer starts at 0 on entry, so the last
  // cycle of a dwell period is at count N-1.
  localparam logic [TIMER_W-1:0] OPEN_LAST = TIMER_W'(OPEN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LAST = TIMER_W'(LOCK_CYCLES - 1);
  localparam logic [FAIL_W-1:0]  FAIL_MAX  = FAIL_W'(MAX_FAILS);

  state_e              state_q, state_d;
  logic [3:0]          code_q, code_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;
  logic                door_q;
  logic                timer_load, timer_inc, timer_done;
  logic [TIMER_W-1:0]  timer_limit;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    fail_d      = fail_q;
    timer_load  = 1'b0;
    timer_inc   = 1'b0;
    timer_limit = (state_q == LOCKED) ? LOCK_LAST : OPEN_LAST;

    case (state_q)
      IDLE: begin
        // Level-sensitive: a held request starts a new check every time
        // the FSM comes back to IDLE.
        if (validate_code) begin
          code_d  = access_code;
          state_d = CHECK;
        end
      end

      CHECK: begin
        if (code_q == VALID_CODE) begin
          fail_d     = '0;
          timer_load = 1'b1;
          state_d    = OPEN;
        end else if ((fail_q + FAIL_W'(1)) == FAIL_MAX) begin
          fail_d     = '0;
          timer_load = 1'b1;
          state_d    = LOCKED;
        end else begin
          fail_d     = fail_q + FAIL_W'(1);
          state_d    = IDLE;
        end
      end

      OPEN, LOCKED: begin
        timer_inc = 1'b1;
        if (timer_done) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rset) begin
      state_q <= IDLE;
      code_q  <= '0;
      fail_q  <= '0;
      door_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      fail_q  <= fail_d;
      // Registered from the next state so the door is a flop output that
      // always equals (state_q == OPEN).
      door_q  <= (state_d == OPEN);
    end
  end

  turnstile_timer #(.W(TIMER_W)) u_timer (
    .clk     (clk),
    .rset    (rset),
    .load_i  (timer_load),
    .inc_i   (timer_inc),
    .limit_i (timer_limit),
    .done_o  (timer_done)
  );

  assign state_out        = state_q;
  assign open_access_door = door_q;

endmodule : metro_turnstile

// File: tb/tb_metro_turnstile.sv
// ---------------------------------------------------------------------------
// tb_metro_turnstile
// Scoreboard bench: the stimulus process feeds a plan-based reference model
// that pushes the expected (state_out, door) pair for every clock edge; a
// separate monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_metro_turnstile;

  localparam int OPEN_N = 4;
  localparam int FAIL_N = 3;
  localparam int LOCK_N = 8;
  localparam logic [3:0] GOOD = 4'd9;

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_CHECK  = 2'b01;
  localparam logic [1:0] S_OPEN   = 2'b10;
  localparam logic [1:0] S_LOCKED = 2'b11;

  logic       clk = 1'b0;
  logic       rset = 1'b0;
  logic       validate_code = 1'b0;
  logic [3:0] access_code = 4'd0;
  logic       open_access_door;
  logic [1:0] state_out;

  typedef struct packed {
    logic [1:0] st;
    logic       door;
  } exp_t;

  exp_t       sb_q[$];     // expected outputs, one per clock edge
  logic [1:0] plan_q[$];   // model: states the gate will visit next
  int         fails_m = 0; // model: consecutive wrong codes
  int         n_checks = 0;
  int         n_fail = 0;

  metro_turnstile dut (
    .clk              (clk),
    .rset             (rset),
    .validate_code    (validate_code),
    .access_code      (access_code),
    .open_access_door (open_access_door),
    .state_out        (state_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: when a code is accepted in IDLE, the whole future
  // visit (CHECK, then OPEN/LOCKED dwell, then back to IDLE) is planned at
  // once. The gate is idle exactly when no plan remains.
  task automatic model(input logic r, input logic v, input logic [3:0] c);
    logic [1:0] nxt;
    exp_t e;
    if (!r) begin
      plan_q.delete();
      fails_m = 0;
      nxt = S_IDLE;
    end else begin
      if (plan_q.size() == 0 && v) begin
        plan_q.push_back(S_CHECK);
        if (c == GOOD) begin
          fails_m = 0;
          repeat (OPEN_N) plan_q.push_back(S_OPEN);
        end else if (fails_m + 1 >= FAIL_N) begin
          fails_m = 0;
          repeat (LOCK_N) plan_q.push_back(S_LOCKED);
        end else begin
          fails_m++;
        end
        plan_q.push_back(S_IDLE);
      end
      nxt = (plan_q.size() > 0) ? plan_q.pop_front() : S_IDLE;
    end
    e.st   = nxt;
    e.door = (nxt == S_OPEN);
    sb_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic v, input logic [3:0] c);
    @(negedge clk);
    rset          = r;
    validate_code = v;
    access_code   = c;
    @(posedge clk);
    model(r, v, c);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 4'd0);
  endtask

  task automatic wrong(input logic [3:0] c);
    step(1'b1, 1'b1, c);
    step(1'b1, 1'b0, 4'd0);
  endtask

  // Monitor: compares whatever the DUT shows against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("state_out", {6'd0, state_out}, {6'd0, e.st});
        check("door", {7'd0, open_access_door}, {7'd0, e.door});
      end
    end
  end

  initial begin
    // Reset held with an active valid request.
    step(1'b0, 1'b1, GOOD);
    step(1'b0, 1'b1, GOOD);
    idle(2);

    // Valid code, single-edge request.
    step(1'b1, 1'b1, GOOD);
    idle(7);

    // Wrong (held through CHECK), then right.
    step(1'b1, 1'b1, 4'd0);
    step(1'b1, 1'b1, 4'd0);
    step(1'b1, 1'b1, GOOD);
    idle(7);

    // Fail counter was cleared: two wrong codes must not lock.
    wrong(4'd5);
    wrong(4'd5);
    idle(2);
    step(1'b1, 1'b1, GOOD);
    idle(6);

    // Lockout with the good code presented while locked.
    wrong(4'd5);
    wrong(4'd5);
    wrong(4'd5);
    repeat (4) step(1'b1, 1'b1, GOOD);
    idle(6);
    step(1'b1, 1'b1, GOOD);
    idle(7);

    // Reset on the 2nd OPEN cycle.
    step(1'b1, 1'b1, GOOD);
    step(1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd0);
    idle(3);

    // Reset mid-LOCKED.
    wrong(4'd3);
    wrong(4'd3);
    wrong(4'd3);
    idle(3);
    step(1'b0, 1'b0, 4'd0);
    idle(3);

    // Held request with the good code: back-to-back openings.
    repeat (14) step(1'b1, 1'b1, GOOD);
    idle(8);

    // Held wrong code: back-to-back checks end in lockout.
    repeat (10) step(1'b1, 1'b1, 4'd2);
    idle(10);

    // Randomised traffic with occasional resets.
    repeat (3000) begin
      logic       r, v;
      logic [3:0] c;
      r = ($urandom_range(0, 99) != 0);
      v = ($urandom_range(0, 1) == 1);
      c = ($urandom_range(0, 2) == 0) ? GOOD : 4'($urandom_range(0, 15));
      step(r, v, c);
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 8'(sb_q.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_metro_turnstile
